// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the unified memory-port arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  localparam logic SEL_IF = 1'b0;
  localparam logic SEL_DM = 1'b1;

  // Wide enough for the largest latency reload value (MEM_LAT-1 <= 7).
  localparam int unsigned CNT_W = 3;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of requester, memory and stall signals around the memory-port arbiter.
interface mem_port_arbiter_if;

  // Handshake: a requester raises *_req with stable address/data and holds it
  // until the matching one-cycle *_ack; rdata is meaningful only in that ack cycle.
  logic        i_if_req;
  logic [31:0] i_if_addr;
  logic        o_if_ack;
  logic [31:0] o_if_rdata;

  logic        i_dm_req;
  logic        i_dm_we;
  logic [31:0] i_dm_addr;
  logic [31:0] i_dm_wdata;
  logic [3:0]  i_dm_be;
  logic        o_dm_ack;
  logic [31:0] o_dm_rdata;

  logic        o_mem_en;
  logic        o_mem_we;
  logic [31:0] o_mem_addr;
  logic [31:0] o_mem_wdata;
  logic [3:0]  o_mem_be;
  logic [31:0] i_mem_rdata;

  logic        o_sel;
  logic        o_stall_if;
  logic        o_stall_dm;

  modport slave (
    input  i_if_req, i_if_addr, i_dm_req, i_dm_we, i_dm_addr, i_dm_wdata, i_dm_be,
           i_mem_rdata,
    output o_if_ack, o_if_rdata, o_dm_ack, o_dm_rdata, o_mem_en, o_mem_we, o_mem_addr,
           o_mem_wdata, o_mem_be, o_sel, o_stall_if, o_stall_dm
  );

  modport master (
    output i_if_req, i_if_addr, i_dm_req, i_dm_we, i_dm_addr, i_dm_wdata, i_dm_be,
           i_mem_rdata,
    input  o_if_ack, o_if_rdata, o_dm_ack, o_dm_rdata, o_mem_en, o_mem_we, o_mem_addr,
           o_mem_wdata, o_mem_be, o_sel, o_stall_if, o_stall_dm
  );

endinterface

// File: rtl/mem_lat_counter.sv
// Loadable down-counter timing the fixed memory latency; done marks the last wait cycle.
module mem_lat_counter #(
  parameter int unsigned W = 3
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         dec_i,
  output logic         done_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done_o = (cnt_q == W'(1));

endmodule

// File: rtl/mux2to1.sv
// Plain 2:1 steering multiplexers used across the datapath (32-bit and 4-bit).
module MUX2To1_32bit (
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic        sel_i,
  output logic [31:0] y_o
);
  assign y_o = sel_i ? b_i : a_i;
endmodule

module MUX2To1_4bit (
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  input  logic       sel_i,
  output logic [3:0] y_o
);
  assign y_o = sel_i ? b_i : a_i;
endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates IF/DM access to the single memory port, sequencing each access
// through IDLE -> ISSUE -> WAIT -> RESP with DM priority bounded by a burst limit.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned MEM_LAT      = 2,
  parameter int unsigned MAX_DM_BURST = 4
) (
  input  logic                i_clk,
  input  logic                i_rst,
  mem_port_arbiter_if.slave   bus,
  output state_t              o_state,
  output logic [2:0]          o_dm_streak
);

  localparam logic [CNT_W-1:0] LAT_LOAD  = CNT_W'(MEM_LAT - 1);
  localparam logic [2:0]       BURST_MAX = 3'(MAX_DM_BURST);
  localparam bit               LAT_GT1   = (MEM_LAT > 1);

  state_t      state_q, state_d;
  logic        sel_q, sel_d;
  logic        we_q, we_d;
  logic [2:0]  streak_q, streak_d;
  logic        mem_en_q, mem_we_q;
  logic        if_ack_q, dm_ack_q;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d;
  logic [3:0]  be_q, be_d;

  logic        any_req, if_forced, grant_dm, latch;
  logic        cnt_load, cnt_dec, cnt_done;
  logic [31:0] addr_mux, wdata_mux;
  logic [3:0]  be_mux;

  assign any_req   = bus.i_if_req | bus.i_dm_req;
  // IF is forced in once DM has won BURST_MAX times in a row while IF waited.
  assign if_forced = bus.i_if_req & (streak_q == BURST_MAX);
  assign grant_dm  = bus.i_dm_req & ~if_forced;
  assign latch     = (state_q == ST_IDLE) & any_req;

  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    we_d     = we_q;
    streak_d = streak_q;
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (any_req) begin
          sel_d    = grant_dm ? SEL_DM : SEL_IF;
          we_d     = grant_dm & bus.i_dm_we;
          streak_d = (grant_dm && bus.i_if_req) ? streak_q + 3'd1 : 3'd0;
          state_d  = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        cnt_load = 1'b1;
        state_d  = LAT_GT1 ? ST_WAIT : ST_RESP;
      end
      ST_WAIT: begin
        cnt_dec = 1'b1;
        if (cnt_done) state_d = ST_RESP;
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Steering follows the grant being made so the bus is valid in the ISSUE cycle.
  MUX2To1_32bit u_addr_mux (
    .a_i(bus.i_if_addr), .b_i(bus.i_dm_addr), .sel_i(sel_d), .y_o(addr_mux)
  );
  MUX2To1_32bit u_wdata_mux (
    .a_i(32'h0), .b_i(bus.i_dm_wdata), .sel_i(sel_d), .y_o(wdata_mux)
  );
  MUX2To1_4bit u_be_mux (
    .a_i(4'hF), .b_i(bus.i_dm_be), .sel_i(sel_d), .y_o(be_mux)
  );

  always_comb begin
    addr_d  = latch ? addr_mux  : addr_q;
    wdata_d = latch ? wdata_mux : wdata_q;
    be_d    = latch ? be_mux    : be_q;
  end

  mem_lat_counter #(.W(CNT_W)) u_lat_cnt (
    .clk_i      (i_clk),
    .rst_i      (i_rst),
    .load_i     (cnt_load),
    .load_val_i (LAT_LOAD),
    .dec_i      (cnt_dec),
    .done_o     (cnt_done)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= ST_IDLE;
      sel_q    <= SEL_IF;
      we_q     <= 1'b0;
      streak_q <= 3'd0;
      mem_en_q <= 1'b0;
      mem_we_q <= 1'b0;
      if_ack_q <= 1'b0;
      dm_ack_q <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      be_q     <= '0;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      we_q     <= we_d;
      streak_q <= streak_d;
      mem_en_q <= (state_d == ST_ISSUE);
      mem_we_q <= (state_d == ST_ISSUE) & we_d;
      if_ack_q <= (state_d == ST_RESP) & (sel_q == SEL_IF);
      dm_ack_q <= (state_d == ST_RESP) & (sel_q == SEL_DM);
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      be_q     <= be_d;
    end
  end

  assign bus.o_sel       = sel_q;
  assign bus.o_mem_en    = mem_en_q;
  assign bus.o_mem_we    = mem_we_q;
  assign bus.o_mem_addr  = addr_q;
  assign bus.o_mem_wdata = wdata_q;
  assign bus.o_mem_be    = be_q;
  assign bus.o_if_ack    = if_ack_q;
  assign bus.o_dm_ack    = dm_ack_q;
  // Read data passes straight through in the ack cycle only; writes return zero.
  assign bus.o_if_rdata  = if_ack_q ? bus.i_mem_rdata : 32'h0;
  assign bus.o_dm_rdata  = (dm_ack_q && !we_q) ? bus.i_mem_rdata : 32'h0;
  assign bus.o_stall_if  = bus.i_if_req & ~if_ack_q;
  assign bus.o_stall_dm  = bus.i_dm_req & ~dm_ack_q;
  assign o_state         = state_q;
  assign o_dm_streak     = streak_q;

endmodule
